// File: rtl/ucaspian_neuron_arbiter.sv
// Round-robin merge of NUM_REQ charge streams into one registered neuron slot; 1 cycle req->neuron_vld.
// Backpressure: req_rdy drops while the slot is full and stalled, or while hold is high.
module ucaspian_neuron_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    input  logic [NUM_REQ*8-1:0]    req_addr,
    input  logic [NUM_REQ*16-1:0]   req_charge,
    input  logic [NUM_REQ-1:0]      req_vld,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic [7:0]              neuron_addr,
    output logic [15:0]             neuron_charge,
    output logic                    neuron_vld,
    input  logic                    neuron_rdy,
    output logic [PW-1:0]           last_grant,
    output logic                    idle
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic          found;
    logic          load;
    logic          xfer;
    logic          vld_next;
    int            j;

    // Scan from the saved pointer with wraparound; first valid requester wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req_vld[j]) begin
                found = 1'b1;
                sel   = PW'(j);
            end
        end
    end

    assign load     = ~reset & ~hold & (~neuron_vld | neuron_rdy);
    assign xfer     = load & found;
    assign vld_next = xfer | (neuron_vld & ~neuron_rdy);

    always_comb begin
        req_rdy = '0;
        if (xfer) begin
            req_rdy[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neuron_vld    <= 1'b0;
            neuron_addr   <= '0;
            neuron_charge <= '0;
            ptr           <= '0;
            last_grant    <= '0;
            idle          <= 1'b1;
        end else begin
            neuron_vld <= vld_next;
            idle       <= ~vld_next & ~|req_vld;
            if (xfer) begin
                neuron_addr   <= req_addr[int'(sel)*8 +: 8];
                neuron_charge <= req_charge[int'(sel)*16 +: 16];
                ptr           <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + PW'(1);
                last_grant    <= sel;
            end
        end
    end

endmodule

// File: tb/tb_ucaspian_neuron_arbiter.sv
// Bench for ucaspian_neuron_arbiter: directed scenarios plus a randomized phase against a queue-based model.
module tb_ucaspian_neuron_arbiter;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          reset, hold, neuron_rdy;
    logic [N*8-1:0]  req_addr;
    logic [N*16-1:0] req_charge;
    logic [N-1:0]  req_vld, req_rdy;
    logic [7:0]    neuron_addr;
    logic [15:0]   neuron_charge;
    logic          neuron_vld, idle;
    logic [0:0]    last_grant;

    always #5 clk = ~clk;

    ucaspian_neuron_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_addr(req_addr), .req_charge(req_charge),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .neuron_addr(neuron_addr), .neuron_charge(neuron_charge),
        .neuron_vld(neuron_vld), .neuron_rdy(neuron_rdy),
        .last_grant(last_grant), .idle(idle)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] c;
    } ev_t;

    ev_t s0[$];
    ev_t s1[$];
    ev_t dlv[$];

    int checks = 0;
    int errors = 0;

    // Reference: one-entry output slot, rotating start index, per-requester queues.
    bit          m_vld;
    logic [7:0]  m_addr;
    logic [15:0] m_chg;
    int          m_ptr, m_lg;
    bit          m_idle;

    logic [7:0] rr_exp [8] = '{8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? s0.size() : s1.size();
    endfunction

    task automatic drive();
        req_vld  = '0;
        req_addr = '0;
        req_charge = '0;
        if (s0.size() > 0) begin
            req_vld[0] = 1'b1; req_addr[7:0] = s0[0].a; req_charge[15:0] = s0[0].c;
        end
        if (s1.size() > 0) begin
            req_vld[1] = 1'b1; req_addr[15:8] = s1[0].a; req_charge[31:16] = s1[0].c;
        end
    endtask

    task automatic tick();
        int g;
        bit load, anyv;
        logic [1:0] er;
        ev_t e;
        drive();
        g = -1;
        load = !reset && !hold && (!m_vld || neuron_rdy);
        if (load) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && qsize((m_ptr + k) % N) > 0) g = (m_ptr + k) % N;
            end
        end
        er = (g >= 0) ? (2'b01 << g) : 2'b00;
        @(negedge clk);
        chk("req_rdy", {30'd0, req_rdy}, {30'd0, er});
        chk("neuron_vld", {31'd0, neuron_vld}, {31'd0, m_vld});
        chk("neuron_addr", {24'd0, neuron_addr}, {24'd0, m_addr});
        chk("neuron_charge", {16'd0, neuron_charge}, {16'd0, m_chg});
        chk("last_grant", {31'd0, last_grant}, m_lg);
        chk("idle", {31'd0, idle}, {31'd0, m_idle});
        anyv = (s0.size() > 0) || (s1.size() > 0);
        if (reset) begin
            m_vld = 0; m_addr = 0; m_chg = 0; m_ptr = 0; m_lg = 0; m_idle = 1;
        end else begin
            if (m_vld && neuron_rdy) dlv.push_back({m_addr, m_chg});
            if (g >= 0) begin
                e = (g == 0) ? s0.pop_front() : s1.pop_front();
                m_vld = 1; m_addr = e.a; m_chg = e.c;
                m_ptr = (g + 1) % N; m_lg = g;
            end else if (neuron_rdy) begin
                m_vld = 0;
            end
            m_idle = !m_vld && !anyv;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; hold = 0; neuron_rdy = 0;
        m_vld = 0; m_addr = 0; m_chg = 0; m_ptr = 0; m_lg = 0; m_idle = 1;
        drive();
        @(posedge clk);
        #1;
        tick();

        // Single requester 1
        reset = 0; neuron_rdy = 1;
        s1.push_back({8'h12, 16'd300});
        tick();
        chk("single_vld", {31'd0, neuron_vld}, 32'd1);
        chk("single_addr", {24'd0, neuron_addr}, 32'h12);
        chk("single_charge", {16'd0, neuron_charge}, 32'd300);
        chk("single_grant", {31'd0, last_grant}, 32'd1);
        tick();
        chk("single_drain", {31'd0, neuron_vld}, 32'd0);

        // Round-robin fairness
        dlv.delete();
        for (int i = 0; i < 4; i++) begin
            s0.push_back({8'(8'h01 + i), 16'($urandom)});
            s1.push_back({8'(8'h81 + i), 16'($urandom)});
        end
        for (int i = 0; i < 9; i++) tick();
        chk("rr_count", dlv.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < dlv.size()) chk("rr_order", {24'd0, dlv[i].a}, {24'd0, rr_exp[i]});
        end

        // Backpressure
        neuron_rdy = 0;
        s0.push_back({8'h33, 16'hFFF9});
        s0.push_back({8'h44, 16'd5});
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("bp_addr", {24'd0, neuron_addr}, 32'h33);
        chk("bp_charge", {16'd0, neuron_charge}, 32'hFFF9);
        dlv.delete();
        neuron_rdy = 1;
        tick();
        chk("bp_next_addr", {24'd0, neuron_addr}, 32'h44);
        tick();
        chk("bp_deliveries", dlv.size(), 32'd2);

        // Hold
        neuron_rdy = 0;
        s0.push_back({8'h55, 16'd1});
        tick();
        hold = 1;
        s0.push_back({8'h66, 16'd2});
        tick(); tick();
        neuron_rdy = 1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("hold_no_grant", {31'd0, neuron_vld}, 32'd0);
        hold = 0;
        tick();
        chk("hold_resume_grant", {31'd0, last_grant}, 32'd0);
        chk("hold_resume_addr", {24'd0, neuron_addr}, 32'h66);

        // Reset mid-stream
        neuron_rdy = 0;
        reset = 1;
        tick();
        chk("rst_vld", {31'd0, neuron_vld}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        reset = 0; neuron_rdy = 1;
        s0.push_back({8'h77, 16'd3});
        s1.push_back({8'hA7, 16'd4});
        tick();
        chk("rst_first_grant", {31'd0, last_grant}, 32'd0);
        tick(); tick();

        // Signed extremes and idle timing
        dlv.delete();
        s1.push_back({8'h10, 16'h8000});
        s1.push_back({8'h11, 16'h7FFF});
        tick();
        tick();
        chk("idle_busy", {31'd0, idle}, 32'd0);
        tick();
        chk("idle_back", {31'd0, idle}, 32'd1);
        chk("signed_count", dlv.size(), 32'd2);
        if (dlv.size() == 2) begin
            chk("charge_min", {16'd0, dlv[0].c}, 32'h8000);
            chk("charge_max", {16'd0, dlv[1].c}, 32'h7FFF);
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (s0.size() < 3 && $urandom_range(0, 1) == 1) s0.push_back(ev_t'($urandom));
            if (s1.size() < 3 && $urandom_range(0, 1) == 1) s1.push_back(ev_t'($urandom));
            hold       = ($urandom_range(0, 9) == 0);
            neuron_rdy = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 0; hold = 0; neuron_rdy = 1;
        for (int c = 0; c < 40 && (s0.size() > 0 || s1.size() > 0 || m_vld); c++) tick();
        tick();
        chk("drain_vld", {31'd0, neuron_vld}, 32'd0);
        chk("drain_idle", {31'd0, idle}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
